dynamic_scan_timer: RTL and testbench

Parametrised scan-timing generator for multiplexed (dynamically lit) 7-segment displays. A prescaler produces a single-cycle clock-enable every DIV clocks. A digit sequencer steps through DIGITS positions with a programmable anti-ghosting blanking window at the start of each slot. It sits between the board clock and the segment/anode drivers and replaces fixed-ratio, toggle-style dividers.

---
 rtl/dynamic_scan_timer_pkg.sv | 23 ++
 rtl/dynamic_scan_timer_scan_prescaler.sv | 40 ++++
 rtl/dynamic_scan_timer.sv | 124 ++++++++++++
 tb/tb_dynamic_scan_timer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dynamic_scan_timer_pkg.sv
// Shared definitions for the multiplexed-display scan timer: sequencer state
// encodings and the width helper used to size the slot and digit counters.
package dynamic_scan_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2_f(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dynamic_scan_timer_scan_prescaler.sv
// Free-running 0..DIV-1 counter that freezes while EN is low and emits a
// registered one-cycle CE on the edge where it wraps back to zero.
module scan_prescaler
    import dynamic_scan_timer_pkg::*;
#(
    parameter int DIV = 20000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    output logic [clog2_f(DIV)-1:0]  Q,
    output logic                     CE
);

    localparam int             QW     = clog2_f(DIV);
    localparam logic [QW-1:0]  Q_LAST = QW'(DIV - 1);

    if (DIV < 2) begin : g_chk_div
        $error("scan_prescaler: DIV must be at least 2");
    end

    logic wrap;

    assign wrap = EN && (Q == Q_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q  <= '0;
            CE <= 1'b0;
        end else begin
            CE <= wrap;
            if (wrap) begin
                Q <= '0;
            end else if (EN) begin
                Q <= Q + QW'(1);
            end
        end
    end

endmodule

// File: rtl/dynamic_scan_timer.sv
// Scan-timing generator for multiplexed 7-segment displays: steps through
// DIGITS anode slots of DIV cycles each, blanking the first BLANK cycles.
//
//   state    | meaning
//   ST_IDLE  | EN low: counters frozen, all anodes off
//   ST_BLANK | inside the anti-ghosting window at the start of a slot
//   ST_DRIVE | current digit's anode enabled
module dynamic_scan_timer
    import dynamic_scan_timer_pkg::*;
#(
    parameter int DIV    = 20000,
    parameter int DIGITS = 4,
    parameter int BLANK  = 2000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    output logic                        CE_OUT,
    output logic [clog2_f(DIGITS)-1:0]  DIGIT_IDX,
    output logic [DIGITS-1:0]           DIGIT_SEL,
    output logic                        BLANK_OUT,
    output logic                        FRAME_END
);

    localparam int             QW       = clog2_f(DIV);
    localparam int             IW       = clog2_f(DIGITS);
    localparam logic [QW-1:0]  Q_LAST   = QW'(DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

    if (DIV < 2) begin : g_chk_div
        $error("dynamic_scan_timer: DIV must be at least 2");
    end
    if (DIGITS < 2) begin : g_chk_digits
        $error("dynamic_scan_timer: DIGITS must be at least 2");
    end
    if (BLANK >= DIV || BLANK < 0) begin : g_chk_blank
        $error("dynamic_scan_timer: BLANK must lie in 0..DIV-1");
    end

    logic [QW-1:0]     q;
    logic [QW-1:0]     q_next;
    logic [IW-1:0]     idx_next;
    logic              wrap;
    logic              in_blank;
    logic [DIGITS-1:0] sel_next;
    scan_state_t       state;
    scan_state_t       state_next;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .Q   (q),
        .CE  (CE_OUT)
    );

    // Mirror the prescaler's next count so the FSM and index land on the
    // same edge as its CE pulse.
    always_comb begin
        wrap     = EN && (q == Q_LAST);
        q_next   = q;
        idx_next = DIGIT_IDX;
        if (wrap) begin
            q_next   = '0;
            idx_next = (DIGIT_IDX == IDX_LAST) ? '0 : DIGIT_IDX + IW'(1);
        end else if (EN) begin
            q_next = q + QW'(1);
        end
        in_blank = int'(q_next) < BLANK;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_BLANK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (EN) begin
                    state_next = in_blank ? ST_BLANK : ST_DRIVE;
                end
            end
            ST_BLANK: begin
                if (!EN) begin
                    state_next = ST_IDLE;
                end else if (!in_blank) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!EN) begin
                    state_next = ST_IDLE;
                end else if (in_blank) begin
                    state_next = ST_BLANK;
                end
            end
            default: state_next = ST_BLANK;
        endcase
        sel_next = '0;
        if (state_next == ST_DRIVE) begin
            sel_next = {{(DIGITS-1){1'b0}}, 1'b1} << idx_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DIGIT_IDX <= '0;
            DIGIT_SEL <= '0;
            BLANK_OUT <= 1'b1;
            FRAME_END <= 1'b0;
        end else begin
            DIGIT_IDX <= idx_next;
            DIGIT_SEL <= sel_next;
            BLANK_OUT <= (state_next != ST_DRIVE);
            FRAME_END <= wrap && (DIGIT_IDX == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_dynamic_scan_timer.sv
// Bench for dynamic_scan_timer: three parameter sets share CLK/RST/EN and are
// compared every cycle against a model built on "enabled edges since reset".
module tb_dynamic_scan_timer;

    localparam int NI = 3;
    localparam int P_DIV [NI] = '{10, 10, 7};
    localparam int P_DIG [NI] = '{4, 3, 5};
    localparam int P_BLK [NI] = '{3, 0, 1};

    logic CLK = 1'b0;
    logic RST;
    logic EN;

    logic       ce_a, fe_a, bo_a;
    logic [1:0] idx_a;
    logic [3:0] sel_a;
    logic       ce_b, fe_b, bo_b;
    logic [1:0] idx_b;
    logic [2:0] sel_b;
    logic       ce_c, fe_c, bo_c;
    logic [2:0] idx_c;
    logic [4:0] sel_c;

    logic [31:0] obs_ce  [NI];
    logic [31:0] obs_fe  [NI];
    logic [31:0] obs_bo  [NI];
    logic [31:0] obs_idx [NI];
    logic [31:0] obs_sel [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_m [NI];
    bit rst_q;
    bit en_q;

    always #5 CLK = ~CLK;

    dynamic_scan_timer #(.DIV(P_DIV[0]), .DIGITS(P_DIG[0]), .BLANK(P_BLK[0])) u_dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .CE_OUT(ce_a), .DIGIT_IDX(idx_a),
        .DIGIT_SEL(sel_a), .BLANK_OUT(bo_a), .FRAME_END(fe_a)
    );
    dynamic_scan_timer #(.DIV(P_DIV[1]), .DIGITS(P_DIG[1]), .BLANK(P_BLK[1])) u_dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .CE_OUT(ce_b), .DIGIT_IDX(idx_b),
        .DIGIT_SEL(sel_b), .BLANK_OUT(bo_b), .FRAME_END(fe_b)
    );
    dynamic_scan_timer #(.DIV(P_DIV[2]), .DIGITS(P_DIG[2]), .BLANK(P_BLK[2])) u_dut_c (
        .CLK(CLK), .RST(RST), .EN(EN), .CE_OUT(ce_c), .DIGIT_IDX(idx_c),
        .DIGIT_SEL(sel_c), .BLANK_OUT(bo_c), .FRAME_END(fe_c)
    );

    assign obs_ce[0]  = 32'(ce_a);
    assign obs_fe[0]  = 32'(fe_a);
    assign obs_bo[0]  = 32'(bo_a);
    assign obs_idx[0] = 32'(idx_a);
    assign obs_sel[0] = 32'(sel_a);
    assign obs_ce[1]  = 32'(ce_b);
    assign obs_fe[1]  = 32'(fe_b);
    assign obs_bo[1]  = 32'(bo_b);
    assign obs_idx[1] = 32'(idx_b);
    assign obs_sel[1] = 32'(sel_b);
    assign obs_ce[2]  = 32'(ce_c);
    assign obs_fe[2]  = 32'(fe_c);
    assign obs_bo[2]  = 32'(bo_c);
    assign obs_idx[2] = 32'(idx_c);
    assign obs_sel[2] = 32'(sel_c);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs follow from t = enabled edges since reset:
    // slot position t mod DIV, digit (t div DIV) mod DIGITS.
    task automatic check_all();
        int q, idx;
        logic [31:0] e_ce, e_fe, e_sel;
        for (int k = 0; k < NI; k++) begin
            q     = t_m[k] % P_DIV[k];
            idx   = (t_m[k] / P_DIV[k]) % P_DIG[k];
            e_ce  = (!rst_q && en_q && q == 0) ? 32'd1 : 32'd0;
            e_fe  = (e_ce == 32'd1 && idx == 0) ? 32'd1 : 32'd0;
            e_sel = (!rst_q && en_q && q >= P_BLK[k]) ? (32'd1 << idx) : 32'd0;
            chk($sformatf("ce%0d", k),    obs_ce[k],  e_ce);
            chk($sformatf("frame%0d", k), obs_fe[k],  e_fe);
            chk($sformatf("idx%0d", k),   obs_idx[k], 32'(idx));
            chk($sformatf("sel%0d", k),   obs_sel[k], e_sel);
            chk($sformatf("blank%0d", k), obs_bo[k],  (e_sel == 32'd0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic step(input bit rst, input bit en);
        @(negedge CLK);
        RST = rst;
        EN  = en;
        @(posedge CLK);
        cyc++;
        rst_q = rst;
        en_q  = en;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                t_m[k] = 0;
            end else if (en) begin
                t_m[k] = t_m[k] + 1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bit r, e;
        RST = 1'b1;
        EN  = 1'b0;
        for (int k = 0; k < NI; k++) t_m[k] = 0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (45) step(1'b0, 1'b1);

        // pause at slot position 6 of digit 1, then resume
        step(1'b1, 1'b1);
        repeat (16) step(1'b0, 1'b1);
        repeat (5)  step(1'b0, 1'b0);
        repeat (11) step(1'b0, 1'b1);

        // reset mid-slot with EN high
        step(1'b1, 1'b1);

        // EN drops exactly on the wrap edge
        repeat (9) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1);

        repeat (800) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 7) != 0);
            step(r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
